enc_seg_display: RTL and testbench
==================================

# enc_seg_display

Four-digit multiplexed seven-segment driver that sits directly downstream of the encoder debounce/counter stage. It resynchronises that stage's 4-bit position value (0..9), tracks the last turn direction and a BCD count of accepted moves, and scans all of it onto a common-anode display. All logic runs on one clock; the position input is treated as asynchronous.

## Interface
- SCAN_DIV, 16'd50000: clocks per digit slot (1 ms at 50 MHz); legal range 2..65535.
- BLINK_TICKS, 9'd250: scan ticks per blink half-period; legal range 1..511.
- clkin  input  1  system clock.
- rst  input  1  reset; synchronous and active-high.
- cnt  input  4  encoder position from the upstream stage, asynchronous to clkin.
- an  output  4  digit enables, active-low; bit 0 is the rightmost digit.
- seg  output  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- Input capture: a three-flop chain cnt_s1 -> cnt_s2 -> cnt_s3.
- Acceptance rule: on any edge where cnt_s2 == cnt_s3 and cnt_s2 != pos_q, load pos_q <= cnt_s2. Unequal samples are ignored.
- Direction: on acceptance, dir <= UP if cnt_s2 > pos_q, else DOWN. Direction has three states: NONE (reset), UP, DOWN.
- Move counter: two BCD digits mv_hi:mv_lo, incremented on each acceptance.
  - mv_lo 9 -> 0 carries into mv_hi.
  - 99 -> 00 wraps silently.
- Digit contents:
  - Digit 0: pos_q as a decimal glyph; values 10..15 show 'E'.
  - Digit 1: 'U' for UP, 'd' for DOWN, '-' for NONE.
  - Digit 2: mv_lo.
  - Digit 3: mv_hi.
  - dp is always off.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. tick is asserted on the cycle where scan_cnt == SCAN_DIV-1; scan_cnt then returns to 0.
  - On tick, dig_idx advances 0->1->2->3->0.
  - an and seg are registered from dig_idx and the current digit contents; exactly one an bit is low outside reset.

## Timing
- Reset values:
  - an = 4'b1111 (all digits off); seg = 8'hFF.
  - pos_q = 0, dir = NONE, mv = 00.
  - dig_idx = 0, scan_cnt = 0, blink_ph = 1 (lit), blink_cnt = 0.
  - The synchroniser flops clear to 0.
- First digit enable: an = 4'b1110 on the first edge after rst deasserts.
- Capture latency: with cnt stable from edge E0, pos_q, dir and mv update at edge E0+4 (s1 at +1, s2 at +2, s3 at +3, accept at +4). Display contents follow one edge later.
- Display refresh: a change is visible the next time its digit is scanned, worst case 4*SCAN_DIV+1 cycles.
- Digit switch: an and seg change on the same edge, one cycle after tick.
- Precedence:
  - rst asserted mid-scan or mid-capture wins over everything and clears all state on that edge.
  - Acceptance and tick on the same edge are independent and both take effect.
- Bounces: cnt toggling faster than two clocks never produces an acceptance, so mv does not count bounces.

## Configuration
- ENC_SEG_LIMIT_BLINK_EN defined:
  - blink_cnt counts ticks; at BLINK_TICKS-1 it wraps and blink_ph toggles.
  - When pos_q is 0 or 9 and blink_ph == 0, digit 0's slot drives seg = 8'hFF. Its an bit still scans normally.
  - Other digits are unaffected.
  - When pos_q moves off a limit, blinking stops immediately. The phase counter keeps running.
- Not defined: blink_cnt and blink_ph are not built, and digit 0 is always lit.

## Structure
- Package enc_seg_pkg:
  - Glyph enum: DIG_0..DIG_9, GLY_U, GLY_D, GLY_DASH, GLY_E, GLY_BLANK.
  - Direction enum: DIR_NONE, DIR_UP, DIR_DOWN.
  - Active-low segment constants for each glyph.
- Sub-module seg7_decode: a purely combinational glyph-to-segment map. It is instantiated once, after the digit mux and before the seg register.

## Test plan
Benches use SCAN_DIV = 4 and BLINK_TICKS = 2.

- Reset: hold rst 3 cycles with cnt = 5 -> an = 1111 and seg = FF during reset; after release, the digit-0 slot shows '0', digit 1 shows '-', digits 3:2 show 00.
- Single step up: cnt 0 -> 1 held stable -> pos_q = 1 exactly 4 edges later; digit 1 shows 'U'; mv = 01.
- Step down: cnt 3 -> 2 -> digit 1 shows 'd'; mv increments by one.
- Glitch rejection: cnt pulses 4 -> 7 -> 4 for one clock -> no acceptance; mv and dir unchanged.
- Wrap: 100 alternating 1/2 steps, each held 6 cycles -> mv goes 99 -> 00 with no other side effect.
- Limit blink (macro on): cnt = 9 stable -> digit-0 slot alternates '9' and blank every 2 ticks. Step to 8 -> steady '8'. With the macro off, '9' stays steady.

Source files
------------

// File: rtl/enc_seg_pkg.sv
// rtl/enc_seg_pkg.sv - glyph/direction types and active-low segment constants for enc_seg_display
package enc_seg_pkg;

    typedef enum logic [3:0] {
        DIG_0, DIG_1, DIG_2, DIG_3, DIG_4, DIG_5, DIG_6, DIG_7, DIG_8, DIG_9,
        GLY_U, GLY_D, GLY_DASH, GLY_E, GLY_BLANK
    } glyph_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_e;

    // Bit order {dp,g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_U     = 8'hC1;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic glyph_e digit_glyph(input logic [3:0] v);
        return (v > 4'd9) ? GLY_E : glyph_e'(v);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational glyph to active-low seven-segment map
module seg7_decode
    import enc_seg_pkg::*;
(
    input  logic [3:0] glyph_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (glyph_e'(glyph_i))
            DIG_0:    seg_o = SEG_0;
            DIG_1:    seg_o = SEG_1;
            DIG_2:    seg_o = SEG_2;
            DIG_3:    seg_o = SEG_3;
            DIG_4:    seg_o = SEG_4;
            DIG_5:    seg_o = SEG_5;
            DIG_6:    seg_o = SEG_6;
            DIG_7:    seg_o = SEG_7;
            DIG_8:    seg_o = SEG_8;
            DIG_9:    seg_o = SEG_9;
            GLY_U:    seg_o = SEG_U;
            GLY_D:    seg_o = SEG_D;
            GLY_DASH: seg_o = SEG_DASH;
            GLY_E:    seg_o = SEG_E;
            default:  seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/enc_seg_display.sv
// rtl/enc_seg_display.sv - encoder position/direction/move-count scanner for a 4-digit common-anode display
// Optional limit blink on digit 0 when ENC_SEG_LIMIT_BLINK_EN is defined.
module enc_seg_display
    import enc_seg_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV    = 16'd50000,
    parameter logic [8:0]  BLINK_TICKS = 9'd250
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic [3:0] cnt,
    output logic [3:0] an,
    output logic [7:0] seg
);

    logic [3:0]  cnt_s1_q, cnt_s2_q, cnt_s3_q;
    logic [3:0]  pos_q, pos_d;
    dir_e        dir_q, dir_d;
    logic [3:0]  mv_lo_q, mv_lo_d, mv_hi_q, mv_hi_d;
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  dig_idx_q, dig_idx_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic        tick, accept, blank_dig0;
    glyph_e      glyph;
    logic [7:0]  dec_seg;

    assign tick   = (scan_cnt_q == SCAN_DIV - 16'd1);
    // Two equal consecutive samples filter both metastability and sub-two-clock bounces
    assign accept = (cnt_s2_q == cnt_s3_q) && (cnt_s2_q != pos_q);

`ifdef ENC_SEG_LIMIT_BLINK_EN
    logic [8:0] blink_cnt_q, blink_cnt_d;
    logic       blink_ph_q, blink_ph_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (tick) begin
            if (blink_cnt_q == BLINK_TICKS - 9'd1) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blank_dig0 = !blink_ph_q && ((pos_q == 4'd0) || (pos_q == 4'd9));
`else
    assign blank_dig0 = 1'b0;
`endif

    always_comb begin
        glyph = GLY_BLANK;
        case (dig_idx_q)
            2'd0:    glyph = blank_dig0 ? GLY_BLANK : digit_glyph(pos_q);
            2'd1:    glyph = (dir_q == DIR_UP)   ? GLY_U :
                             (dir_q == DIR_DOWN) ? GLY_D : GLY_DASH;
            2'd2:    glyph = digit_glyph(mv_lo_q);
            default: glyph = digit_glyph(mv_hi_q);
        endcase
    end

    seg7_decode u_decode (
        .glyph_i (glyph),
        .seg_o   (dec_seg)
    );

    always_comb begin
        pos_d      = pos_q;
        dir_d      = dir_q;
        mv_lo_d    = mv_lo_q;
        mv_hi_d    = mv_hi_q;
        scan_cnt_d = tick ? 16'd0 : scan_cnt_q + 16'd1;
        dig_idx_d  = tick ? dig_idx_q + 2'd1 : dig_idx_q;
        an_d       = ~(4'b0001 << dig_idx_q);
        seg_d      = dec_seg;
        if (accept) begin
            pos_d = cnt_s2_q;
            dir_d = (cnt_s2_q > pos_q) ? DIR_UP : DIR_DOWN;
            if (mv_lo_q == 4'd9) begin
                mv_lo_d = 4'd0;
                mv_hi_d = (mv_hi_q == 4'd9) ? 4'd0 : mv_hi_q + 4'd1;
            end else begin
                mv_lo_d = mv_lo_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            cnt_s1_q   <= '0;
            cnt_s2_q   <= '0;
            cnt_s3_q   <= '0;
            pos_q      <= '0;
            dir_q      <= DIR_NONE;
            mv_lo_q    <= '0;
            mv_hi_q    <= '0;
            scan_cnt_q <= '0;
            dig_idx_q  <= '0;
            an_q       <= 4'b1111;
            seg_q      <= 8'hFF;
        end else begin
            cnt_s1_q   <= cnt;
            cnt_s2_q   <= cnt_s1_q;
            cnt_s3_q   <= cnt_s2_q;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            mv_lo_q    <= mv_lo_d;
            mv_hi_q    <= mv_hi_d;
            scan_cnt_q <= scan_cnt_d;
            dig_idx_q  <= dig_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_enc_seg_display.sv
// tb/tb_enc_seg_display.sv - randomized self-checking bench for enc_seg_display against a history-based model
module tb_enc_seg_display;

    localparam int SD = 4;
    localparam int BT = 2;

    logic       clkin = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] cnt   = 4'd0;
    logic [3:0] an;
    logic [7:0] seg;

    enc_seg_display #(.SCAN_DIV(16'd4), .BLINK_TICKS(9'd2)) dut (
        .clkin (clkin),
        .rst   (rst),
        .cnt   (cnt),
        .an    (an),
        .seg   (seg)
    );

    always #5 clkin = ~clkin;

    int n_checks = 0;
    int n_errors = 0;

    // Model state as seen just before the current edge; hist holds the cnt value sampled at each edge
    int m_pos, m_dir, m_mv, m_edge;
    int hist[$];
    logic [7:0] gl_tab [0:13];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at edge %0d", tag, obs, exp_v, m_edge);
        end
    endtask

    function automatic logic [7:0] exp_seg_for(int dig);
`ifdef ENC_SEG_LIMIT_BLINK_EN
        int ticks = (m_edge - 1) / SD;
        bit lit   = ((ticks / BT) % 2) == 0;
`endif
        case (dig)
            0: begin
`ifdef ENC_SEG_LIMIT_BLINK_EN
                if (!lit && (m_pos == 0 || m_pos == 9)) return 8'hFF;
`endif
                return (m_pos > 9) ? gl_tab[13] : gl_tab[m_pos];
            end
            1:       return (m_dir == 1) ? gl_tab[10] : (m_dir == 2) ? gl_tab[11] : gl_tab[12];
            2:       return gl_tab[m_mv % 10];
            default: return gl_tab[m_mv / 10];
        endcase
    endfunction

    task automatic cycle(input logic [3:0] v, input logic r);
        logic [3:0] ea;
        logic [7:0] es;
        int dig, a, b;
        @(negedge clkin);
        cnt = v;
        rst = r;
        @(posedge clkin);
        if (r) begin
            m_pos = 0; m_dir = 0; m_mv = 0; m_edge = 0;
            hist = '{0, 0, 0};
            ea = 4'hF;
            es = 8'hFF;
        end else begin
            m_edge++;
            dig = ((m_edge - 1) / SD) % 4;
            ea  = ~(4'b0001 << dig);
            es  = exp_seg_for(dig);
            a = hist[hist.size() - 2];
            b = hist[hist.size() - 3];
            if (a == b && a != m_pos) begin
                m_dir = (a > m_pos) ? 1 : 2;
                m_pos = a;
                m_mv  = (m_mv + 1) % 100;
            end
            hist.push_back(int'(v));
            if (hist.size() > 8) void'(hist.pop_front());
        end
        #1;
        chk("an", 32'(an), 32'(ea));
        chk("seg", 32'(seg), 32'(es));
        if (!r) begin
            chk("pos", 32'(dut.pos_q), m_pos);
            chk("mv", 32'(dut.mv_hi_q) * 10 + 32'(dut.mv_lo_q), m_mv);
        end
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) cycle(v, 1'b0);
    endtask

    initial begin
        gl_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
                   8'hC1, 8'hA1, 8'hBF, 8'h86};
        m_edge = 0;

        for (int i = 0; i < 3; i++) cycle(4'd5, 1'b1);
        hold(4'd0, 20);

        hold(4'd1, 16);
        hold(4'd3, 16);
        hold(4'd2, 20);

        hold(4'd4, 16);
        hold(4'd7, 1);
        hold(4'd4, 20);

        for (int i = 0; i < 100; i++) hold((i % 2 == 0) ? 4'd1 : 4'd2, 6);

        hold(4'd9, 48);
        hold(4'd8, 24);
        hold(4'd0, 40);

        for (int i = 0; i < 80; i++) hold(4'($urandom_range(0, 15)), $urandom_range(1, 5));

        hold(4'd6, 2);
        cycle(4'd3, 1'b1);
        cycle(4'd3, 1'b1);
        hold(4'd3, 20);

        for (int i = 0; i < 80; i++) hold(4'($urandom_range(0, 15)), $urandom_range(1, 4));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
